calc_seq_p: RTL
===============

CALC_SEQ_P -- requirements
Module: calc_seq_p

Interface
REQ-001 Parameter DIGITS, default 8: number of decimal display digits; entry limit and result limit are both 10^DIGITS-1.
REQ-002 Parameter W, default 27: width of the operand, result and product registers; SHALL satisfy 2^W > 10^DIGITS-1.
REQ-003 Port clock, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 Port cmd, input, 4 bits: 0-9 digit, 1010 add, 1011 sub, 1100 mul, 1101 clear-entry, 1110 equals, 1111 backspace.
REQ-006 Port cmd_valid, input, 1 bit: cmd is offered this cycle.
REQ-007 Port status, output, 2 bits: 00 error, 01 busy, 10 ready.
REQ-008 Port data, output, 4 bits: BCD digit currently scanned.
REQ-009 Port pos, output, $clog2(DIGITS) bits: display index of data; 0 is the least significant digit.
REQ-010 Port data_valid, output, 1 bit: data/pos valid this cycle.
REQ-011 Port neg, output, 1 bit: displayed value is negative.
REQ-012 Port state, output, 3 bits: current FSM state, for debug.

Function
REQ-013 Handshake: a command SHALL be accepted only when cmd_valid=1 and status=10; cmd_valid while status=01 or 00 SHALL be ignored and not queued.
REQ-014 Status after acceptance: status SHALL be 01 from the next cycle until the print scan completes, then return to 10.
REQ-015 FSM states: ENTRY_A, ENTRY_B, COMPUTE, PRINT, ERROR; every accepted command SHALL end in PRINT, except commands that enter ERROR.
REQ-016 Digit entry: entry = entry*10 + d; if the new value would exceed 10^DIGITS-1, the digit SHALL be dropped and the value reprinted unchanged.
REQ-017 Backspace: entry = entry/10; clear-entry: entry = 0; on 0 both SHALL remain 0 without error.
REQ-018 ENTRY_A + op: regA = entry, op latched, entry = 0, then PRINT, then ENTRY_B.
REQ-019 ENTRY_A + equals: no operation; value reprinted.
REQ-020 ENTRY_B + op: ERROR.
REQ-021 ENTRY_B + equals: regB = entry, then COMPUTE.
REQ-022 Add: result = regA + regB, one COMPUTE cycle.
REQ-023 Sub: result = |regA - regB|, one COMPUTE cycle; neg = 1 when regB > regA.
REQ-024 Mul: shift-and-add, one multiplier bit per cycle; SHALL finish within W cycles and terminate early once the remaining multiplier bits are zero.
REQ-025 Overflow: a result above 10^DIGITS-1 SHALL enter ERROR; mul SHALL abort on the first overflowing partial sum.
REQ-026 After COMPUTE: result goes to PRINT, then ENTRY_A with entry = result, so chaining is possible.
REQ-027 Digit entered over a result: SHALL start a new number and clear neg.
REQ-028 Op pressed while neg = 1: SHALL enter ERROR.
REQ-029 PRINT: exactly DIGITS consecutive cycles with data_valid = 1 and pos = 0..DIGITS-1 in order; data = (value / 10^pos) mod 10; value is frozen for the scan.
REQ-030 ERROR: status = 00, data_valid = 0; SHALL hold until reset.

Reset
REQ-031 Reset SHALL set state = ENTRY_A, status = 10, and data, pos, data_valid, neg, entry, regA, regB and op all to 0.
REQ-032 Reset asserted mid-COMPUTE or mid-PRINT SHALL abort immediately; reset has priority over every command.

Structure
REQ-033 Shared package calc_pkg SHALL hold the cmd encodings, the status codes and the state enum.
REQ-034 Sub-module calc_digit_scan SHALL perform the PRINT scan (load value, emit one digit per cycle by successive /10, pulse done); it SHALL be parametrised by DIGITS and W.

Verification (DIGITS = 8)
REQ-035 Entry 1, 2, 3, add, 4, 5, equals -> scan outputs digits 8, 6, 1, 0, 0, 0, 0, 0 at pos 0..7, neg = 0, status returns to 10.
REQ-036 Entry 5, sub, 9, equals -> scan outputs 4 then seven 0s, neg = 1; then pressing add -> status = 00.
REQ-037 Entry 9999, mul, 9999, equals -> result 99980001 and busy for at most W + 1 + DIGITS cycles; entry 99999999, mul, 2, equals -> status = 00.
REQ-038 Nine digits 1 entered -> value 11111111 (ninth digit dropped); backspace -> 1111111; clear-entry -> 0.
REQ-039 cmd_valid pulsed during a PRINT scan -> command ignored and value unchanged; add pressed in ENTRY_B -> status = 00 until reset.
REQ-040 Reset asserted on the third mul cycle -> next cycle state = ENTRY_A, status = 10, all outputs 0.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator sequencer.
//   - cmd encodings (digits 0-9 are the raw value)
//   - status codes driven on calc_seq_p.status
//   - FSM state and latched-operation enums
//   - pow10() for elaborating the display limit 10^DIGITS-1
package calc_pkg;

  localparam logic [3:0] CMD_ADD  = 4'b1010;
  localparam logic [3:0] CMD_SUB  = 4'b1011;
  localparam logic [3:0] CMD_MUL  = 4'b1100;
  localparam logic [3:0] CMD_CLR  = 4'b1101;
  localparam logic [3:0] CMD_EQ   = 4'b1110;
  localparam logic [3:0] CMD_BKSP = 4'b1111;

  localparam logic [1:0] STAT_ERROR = 2'b00;
  localparam logic [1:0] STAT_BUSY  = 2'b01;
  localparam logic [1:0] STAT_READY = 2'b10;

  typedef enum logic [2:0] {
    ENTRY_A = 3'd0,
    ENTRY_B = 3'd1,
    COMPUTE = 3'd2,
    PRINT   = 3'd3,
    ERROR   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/calc_digit_scan.sv
// calc_digit_scan: serialises a binary value into DIGITS BCD digits,
// least significant first, one digit per clock by successive /10.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   start          : one-cycle pulse; value is captured and digit 0 is
//                    emitted in this same cycle
//   value          : binary value to print (held stable by the caller)
//   data, pos      : current BCD digit and its display index
//   data_valid     : data/pos valid this cycle
//   done           : high on the cycle carrying the last digit
module calc_digit_scan
  import calc_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int W      = 27,
  localparam int PW    = $clog2(DIGITS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  value,
  output logic [3:0]    data,
  output logic [PW-1:0] pos,
  output logic          data_valid,
  output logic          done
);

  logic [W-1:0]  cur;
  logic [PW-1:0] idx;
  logic          active;
  logic [W-1:0]  src;

  // On the start cycle the digit comes straight from value, so the scan
  // occupies exactly DIGITS cycles with no load bubble.
  assign src        = start ? value : cur;
  assign data       = 4'(src % W'(10));
  assign pos        = start ? '0 : idx;
  assign data_valid = start | active;
  assign done       = data_valid && (pos == PW'(DIGITS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cur    <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (data_valid) begin
      cur <= src / W'(10);
      if (done) begin
        idx    <= '0;
        active <= 1'b0;
      end else begin
        idx    <= pos + PW'(1);
        active <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_seq_p.sv
// calc_seq_p: four-function decimal calculator sequencer.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   cmd          : 0-9 digit, A add, B sub, C mul, D clear-entry,
//                  E equals, F backspace
//   cmd_valid    : cmd offered; taken only while status = ready
//   status       : 00 error, 01 busy, 10 ready
//   data, pos    : BCD digit being scanned and its index (0 = LSD)
//   data_valid   : data/pos valid
//   neg          : displayed value is negative
//   state        : FSM state for debug
//
// state   | meaning
// ENTRY_A | typing first operand (or holding a result for chaining)
// ENTRY_B | op latched, typing second operand
// COMPUTE | add/sub (one cycle) or shift-and-add multiply
// PRINT   | digit scan running, returns to ret_st when done
// ERROR   | sticky until reset
module calc_seq_p
  import calc_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int W      = 27
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                cmd,
  input  logic                      cmd_valid,
  output logic [1:0]                status,
  output logic [3:0]                data,
  output logic [$clog2(DIGITS)-1:0] pos,
  output logic                      data_valid,
  output logic                      neg,
  output logic [2:0]                state
);

  localparam logic [W-1:0] MAX_W  = W'(pow10(DIGITS) - 64'd1);
  localparam logic [W:0]   MAX_W1 = {1'b0, MAX_W};
  localparam logic [W+1:0] MAX_W2 = {2'b0, MAX_W};
  localparam logic [W+3:0] MAX_W4 = {4'b0, MAX_W};

  state_e       st, ret_st;
  op_e          op;
  logic [W-1:0] entry, rega, regb, acc, mplier, disp;
  logic [W:0]   mcand;
  logic         big, fresh, start, scan_done;

  // entry edit for digit / backspace / clear-entry
  logic         is_digit, is_op;
  logic [W+3:0] ent_app;
  logic [W-1:0] ent_next;

  assign is_digit = (cmd <= 4'd9);
  assign is_op    = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_MUL);
  assign ent_app  = {4'b0, entry} * (W+4)'(10) + (W+4)'(cmd);

  always_comb begin
    ent_next = entry;
    if (is_digit) begin
      // a digit typed over a result starts a fresh number
      if (fresh)                    ent_next = W'(cmd);
      else if (ent_app <= MAX_W4)   ent_next = ent_app[W-1:0];
    end else if (cmd == CMD_BKSP) begin
      ent_next = entry / W'(10);
    end else if (cmd == CMD_CLR) begin
      ent_next = '0;
    end
  end

  // Multiply step. Once the shifted multiplicand exceeds the display limit
  // it is no longer tracked; 'big' alone is enough to flag overflow as soon
  // as another multiplier bit is set.
  logic [W+1:0] mul_sum;
  logic [W:0]   mcand_nxt;
  logic [W-1:0] acc_nxt;
  logic         big_nxt, mul_ovf;

  assign mul_sum   = {2'b0, acc} + {1'b0, mcand};
  assign mul_ovf   = mplier[0] && (big || (mul_sum > MAX_W2));
  assign acc_nxt   = mplier[0] ? mul_sum[W-1:0] : acc;
  assign mcand_nxt = big ? mcand : {mcand[W-1:0], 1'b0};
  assign big_nxt   = big || (mcand_nxt > MAX_W1);

  logic [W:0]   add_sum;
  logic [W-1:0] res_val;
  logic         res_neg, res_done, res_err;

  assign add_sum = {1'b0, rega} + {1'b0, regb};

  always_comb begin
    res_val  = '0;
    res_neg  = 1'b0;
    res_done = 1'b0;
    res_err  = 1'b0;
    case (op)
      OP_ADD: begin
        res_done = 1'b1;
        res_err  = (add_sum > MAX_W1);
        res_val  = add_sum[W-1:0];
      end
      OP_SUB: begin
        res_done = 1'b1;
        res_neg  = (regb > rega);
        res_val  = res_neg ? (regb - rega) : (rega - regb);
      end
      default: begin
        res_err  = mul_ovf;
        res_done = ((mplier >> 1) == '0);
        res_val  = acc_nxt;
      end
    endcase
  end

  calc_digit_scan #(
    .DIGITS(DIGITS),
    .W     (W)
  ) u_scan (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .value     (disp),
    .data      (data),
    .pos       (pos),
    .data_valid(data_valid),
    .done      (scan_done)
  );

  assign state = st;

  always_ff @(posedge clock) begin
    if (reset) begin
      st     <= ENTRY_A;
      ret_st <= ENTRY_A;
      status <= STAT_READY;
      op     <= OP_ADD;
      entry  <= '0;
      rega   <= '0;
      regb   <= '0;
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
      disp   <= '0;
      big    <= 1'b0;
      fresh  <= 1'b0;
      neg    <= 1'b0;
      start  <= 1'b0;
    end else begin
      start <= 1'b0;
      case (st)
        ENTRY_A, ENTRY_B: begin
          if (cmd_valid) begin
            if (is_op) begin
              if (st == ENTRY_B || neg) begin
                st     <= ERROR;
                status <= STAT_ERROR;
              end else begin
                // operand A is shown while operand B is typed
                rega   <= entry;
                op     <= (cmd == CMD_ADD) ? OP_ADD :
                          (cmd == CMD_SUB) ? OP_SUB : OP_MUL;
                entry  <= '0;
                fresh  <= 1'b0;
                disp   <= entry;
                ret_st <= ENTRY_B;
                st     <= PRINT;
                start  <= 1'b1;
                status <= STAT_BUSY;
              end
            end else if (cmd == CMD_EQ && st == ENTRY_B) begin
              regb   <= entry;
              acc    <= '0;
              mcand  <= {1'b0, rega};
              mplier <= entry;
              big    <= 1'b0;
              st     <= COMPUTE;
              status <= STAT_BUSY;
            end else begin
              // digit, backspace, clear-entry, or equals with nothing pending
              entry <= ent_next;
              disp  <= ent_next;
              if (is_digit || cmd == CMD_CLR) begin
                fresh <= 1'b0;
                neg   <= 1'b0;
              end
              ret_st <= st;
              st     <= PRINT;
              start  <= 1'b1;
              status <= STAT_BUSY;
            end
          end
        end
        COMPUTE: begin
          if (res_err) begin
            st     <= ERROR;
            status <= STAT_ERROR;
          end else begin
            acc    <= acc_nxt;
            mplier <= mplier >> 1;
            mcand  <= mcand_nxt;
            big    <= big_nxt;
            if (res_done) begin
              entry  <= res_val;
              disp   <= res_val;
              neg    <= res_neg;
              fresh  <= 1'b1;
              ret_st <= ENTRY_A;
              st     <= PRINT;
              start  <= 1'b1;
            end
          end
        end
        PRINT: begin
          if (scan_done) begin
            st     <= ret_st;
            status <= STAT_READY;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
